// File: rtl/dual_port_ram_if.sv
// One memory port: request, byte strobes, write data and the read/valid/error
// response. The RAM owns the slave side; the requester owns the master side.
interface dual_port_ram_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;

    modport master (
        output req, addr, we, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  req, addr, we, wdata,
        output rdata, rvalid, err
    );
endinterface

// File: rtl/dual_port_ram.sv
// Byte-addressable true dual-port RAM with a fill sequencer that writes
// FILL_WORD to every aligned word after reset or on init_req. Port A feeds
// instruction fetch, port B serves data accesses. Both ports read the array as
// it was before the current edge's writes; on a same-byte write collision,
// port B wins.
module dual_port_ram #(
    parameter int          DEPTH_BYTES = 1024,
    parameter int          ADDR_W      = 32,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] FILL_WORD   = 32'h275EFBCF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init_req,
    output logic            ready,
    dual_port_ram_if.slave  a,
    dual_port_ram_if.slave  b
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic {FILL, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [7:0] mem [DEPTH_BYTES];

    // Port views packed as two-entry arrays: index 0 is port A, index 1 is port B.
    logic              p_req   [2];
    logic [ADDR_W-1:0] p_addr  [2];
    logic [3:0]        p_we    [2];
    logic [31:0]       p_wdata [2];

    logic              acc     [2];
    logic              in_rng  [2];
    logic [IDX_W-1:0]  idx     [2][4];
    logic [3:0]        wen     [2];
    logic [31:0]       rd_comb [2];

    assign p_req[0]   = a.req;
    assign p_addr[0]  = a.addr;
    assign p_we[0]    = a.we;
    assign p_wdata[0] = a.wdata;
    assign p_req[1]   = b.req;
    assign p_addr[1]  = b.addr;
    assign p_we[1]    = b.we;
    assign p_wdata[1] = b.wdata;

    // Fill/run sequencer; ready is registered and mirrors state == RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (cnt == CNT_W'(WORDS - 1)) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (init_req) begin
                        state <= FILL;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-port decode: range check, wrapped byte indices, strobes and old read data.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p]     = p_req[p] & ready;
            in_rng[p]  = p_addr[p] < ADDR_W'(DEPTH_BYTES);
            wen[p]     = 4'b0000;
            rd_comb[p] = 32'h0;
            for (int i = 0; i < 4; i++) begin
                // Truncation to IDX_W bits gives the modulo-DEPTH_BYTES wrap.
                idx[p][i] = p_addr[p][IDX_W-1:0] + IDX_W'(i);
                wen[p][i] = acc[p] & in_rng[p] & p_we[p][i];
                if (in_rng[p]) begin
                    rd_comb[p][8*i +: 8] = mem[idx[p][i]];
                end
            end
        end
    end

    // Array writes: fill word during FILL, port strobes in RUN; B is applied last so it wins a collision.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            for (int k = 0; k < 4; k++) begin
                mem[{cnt, 2'(k)}] <= FILL_WORD[8*k +: 8];
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[p][i]) begin
                    mem[idx[p][i]] <= p_wdata[p][8*i +: 8];
                end
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_comb_rd
            assign a.rdata  = acc[0] ? rd_comb[0] : 32'h0;
            assign a.err    = acc[0] & ~in_rng[0];
            assign a.rvalid = acc[0];
            assign b.rdata  = acc[1] ? rd_comb[1] : 32'h0;
            assign b.err    = acc[1] & ~in_rng[1];
            assign b.rvalid = acc[1];
        end else begin : g_reg_rd
            logic [31:0] rdata_p0 [2];
            logic        err_p0   [2];
            logic        vld_p0   [2];

            // Read stage p0: capture old data and error; hold them while no request is accepted.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int p = 0; p < 2; p++) begin
                        rdata_p0[p] <= 32'h0;
                        err_p0[p]   <= 1'b0;
                        vld_p0[p]   <= 1'b0;
                    end
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        vld_p0[p] <= acc[p];
                        if (acc[p]) begin
                            rdata_p0[p] <= rd_comb[p];
                            err_p0[p]   <= ~in_rng[p];
                        end
                    end
                end
            end

            assign a.rdata  = rdata_p0[0];
            assign a.err    = err_p0[0];
            assign a.rvalid = vld_p0[0];
            assign b.rdata  = rdata_p0[1];
            assign b.err    = err_p0[1];
            assign b.rvalid = vld_p0[1];
        end
    endgenerate
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench: a 1 KiB registered-read RAM (dut0) and a 16-byte
// combinational-read RAM (dut1) share clock and reset. Inputs change and
// outputs are sampled on the falling edge.
module tb_dual_port_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init0 = 1'b0;
    logic init1 = 1'b0;
    logic rdy0;
    logic rdy1;

    int total = 0;
    int bad   = 0;

    dual_port_ram_if a0 ();
    dual_port_ram_if b0 ();
    dual_port_ram_if a1 ();
    dual_port_ram_if b1 ();

    always #5 clk = ~clk;

    dual_port_ram #(
        .DEPTH_BYTES(1024), .ADDR_W(32), .RD_LAT(1), .FILL_WORD(32'h275EFBCF)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .init_req(init0), .ready(rdy0), .a(a0), .b(b0)
    );

    dual_port_ram #(
        .DEPTH_BYTES(16), .ADDR_W(32), .RD_LAT(0), .FILL_WORD(32'h275EFBCF)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init_req(init1), .ready(rdy1), .a(a1), .b(b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        a0.req = 0; a0.addr = '0; a0.we = '0; a0.wdata = '0;
        b0.req = 0; b0.addr = '0; b0.we = '0; b0.wdata = '0;
        a1.req = 0; a1.addr = '0; a1.we = '0; a1.wdata = '0;
        b1.req = 0; b1.addr = '0; b1.we = '0; b1.wdata = '0;
    endtask

    // One port-A access on dut0: present for one edge, then withdraw.
    task automatic acc_a0(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
        a0.req = 1; a0.addr = addr; a0.we = we; a0.wdata = wd;
        step();
        a0.req = 0; a0.we = '0;
    endtask

    task automatic acc_b0(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
        b0.req = 1; b0.addr = addr; b0.we = we; b0.wdata = wd;
        step();
        b0.req = 0; b0.we = '0;
    endtask

    task automatic wait_ready0(output int n);
        n = 0;
        while (!rdy0 && n < 400) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int n1;
        idle_all();

        // Reset values
        step();
        step();
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_rvalid", 32'(a0.rvalid), 32'd0);
        chk("rst_rdata", a0.rdata, 32'h0);
        chk("rst_err", 32'(a0.err), 32'd0);

        // Fill after reset release: 256 edges (dut0), 4 edges (dut1)
        rst_n = 1'b1;
        n = 0;
        n1 = 0;
        while (!rdy0 && n < 400) begin
            step();
            n++;
            if (rdy1 && n1 == 0) n1 = n;
        end
        chk("fill_edges", 32'(n), 32'd256);
        chk("fill_edges_small", 32'(n1), 32'd4);

        // Fill pattern reads
        acc_a0(32'h000, 4'h0, 32'h0);
        chk("rd000_vld", 32'(a0.rvalid), 32'd1);
        chk("rd000", a0.rdata, 32'h275EFBCF);
        chk("rd000_err", 32'(a0.err), 32'd0);
        acc_a0(32'h004, 4'h0, 32'h0);
        chk("rd004", a0.rdata, 32'h275EFBCF);
        acc_a0(32'h3FC, 4'h0, 32'h0);
        chk("rd3fc", a0.rdata, 32'h275EFBCF);

        // Byte strobes; the write request also reads the old word
        acc_a0(32'h010, 4'b0101, 32'hAABBCCDD);
        chk("wr010_vld", 32'(a0.rvalid), 32'd1);
        chk("wr010_old", a0.rdata, 32'h275EFBCF);
        step();
        chk("vld_one_cycle", 32'(a0.rvalid), 32'd0);
        chk("rdata_hold", a0.rdata, 32'h275EFBCF);
        acc_a0(32'h010, 4'h0, 32'h0);
        chk("rd010", a0.rdata, 32'h27BBFBDD);

        // Wrap-around write through port B
        acc_b0(32'h3FE, 4'hF, 32'h11223344);
        chk("wr3fe_vld", 32'(b0.rvalid), 32'd1);
        acc_b0(32'h3FE, 4'h0, 32'h0);
        chk("rd3fe", b0.rdata, 32'h11223344);
        acc_b0(32'h000, 4'h0, 32'h0);
        chk("rd000_wrap", b0.rdata, 32'h275E1122);

        // Out of range: error, zero data, write suppressed
        acc_a0(32'h400, 4'hF, 32'hFFFFFFFF);
        chk("oor_err", 32'(a0.err), 32'd1);
        chk("oor_rdata", a0.rdata, 32'h0);
        chk("oor_vld", 32'(a0.rvalid), 32'd1);
        acc_a0(32'h000, 4'h0, 32'h0);
        chk("oor_nowrite", a0.rdata, 32'h275E1122);
        chk("oor_err_clr", 32'(a0.err), 32'd0);

        // Collision on the same edge
        a0.req = 1; a0.addr = 32'h020; a0.we = 4'hF; a0.wdata = 32'h01010101;
        b0.req = 1; b0.addr = 32'h022; b0.we = 4'hF; b0.wdata = 32'h02020202;
        step();
        idle_all();
        chk("coll_readold", a0.rdata, 32'h275EFBCF);
        acc_a0(32'h020, 4'h0, 32'h0);
        chk("coll_rd020", a0.rdata, 32'h02020101);
        acc_a0(32'h024, 4'h0, 32'h0);
        chk("coll_rd024", a0.rdata, 32'h275E0202);

        // Write on A, read on B the very next cycle
        acc_a0(32'h030, 4'hF, 32'h12345678);
        acc_b0(32'h030, 4'h0, 32'h0);
        chk("wr_then_rd", b0.rdata, 32'h12345678);

        // Dirty 0x040, then init_req with a concurrent read
        acc_a0(32'h040, 4'hF, 32'hDEADBEEF);
        acc_a0(32'h040, 4'h0, 32'h0);
        chk("rd040_dirty", a0.rdata, 32'hDEADBEEF);
        init0 = 1'b1;
        b0.req = 1; b0.addr = 32'h040; b0.we = 4'h0;
        step();
        init0 = 1'b0;
        b0.req = 0;
        chk("init_ready_drop", 32'(rdy0), 32'd0);
        chk("init_req_served", 32'(b0.rvalid), 32'd1);
        chk("init_req_data", b0.rdata, 32'hDEADBEEF);
        // Requests during FILL are ignored
        a0.req = 1; a0.addr = 32'h400; a0.we = 4'h0;
        step();
        a0.req = 0;
        chk("fill_ign_vld", 32'(a0.rvalid), 32'd0);
        chk("fill_ign_err", 32'(a0.err), 32'd0);
        wait_ready0(n);
        chk("refill_edges", 32'(n + 1), 32'd256);
        acc_a0(32'h040, 4'h0, 32'h0);
        chk("rd040_refill", a0.rdata, 32'h275EFBCF);

        // Asynchronous reset at fill edge 100
        init0 = 1'b1;
        step();
        init0 = 1'b0;
        repeat (100) step();
        chk("midfill_busy", 32'(rdy0), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdata", a0.rdata, 32'h0);
        chk("async_rst_rdata_b", b0.rdata, 32'h0);
        chk("async_rst_ready_small", 32'(rdy1), 32'd0);
        step();
        rst_n = 1'b1;
        wait_ready0(n);
        chk("rst_refill_edges", 32'(n), 32'd256);
        acc_a0(32'h010, 4'h0, 32'h0);
        chk("rd010_refill", a0.rdata, 32'h275EFBCF);

        // Combinational-read build (dut1, 16 bytes)
        a1.req = 1; a1.addr = 32'h4; a1.we = 4'b0101; a1.wdata = 32'hAABBCCDD;
        #1;
        chk("c_vld", 32'(a1.rvalid), 32'd1);
        chk("c_old", a1.rdata, 32'h275EFBCF);
        step();
        a1.we = 4'h0;
        #1;
        chk("c_rd004", a1.rdata, 32'h27BBFBDD);
        a1.addr = 32'h10;
        #1;
        chk("c_oor_err", 32'(a1.err), 32'd1);
        chk("c_oor_rdata", a1.rdata, 32'h0);
        a1.req = 0;
        #1;
        chk("c_vld_off", 32'(a1.rvalid), 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Parametrised, byte-addressable, true dual-port RAM that replaces the fixed 1 KiB instruction/data memory. It adds configurable depth and read latency, per-port request/valid handshakes, range-error reporting and a deterministic collision rule. A hardware fill sequencer preloads every word with a fill pattern after reset or on demand. Port A feeds the IF stage; port B serves immediate/data accesses.

## Interface
- DEPTH_BYTES, 1024: memory size in bytes. Power of two, ≥ 8.
- ADDR_W, 32: width of the byte-address ports.
- RD_LAT, 1: read latency. 0 = combinational read; 1 = registered read.
- FILL_WORD, 32'h275EFBCF: word written to every aligned word by the fill sequencer (the NOP encoding).

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse: restart the fill sequence (honoured only when ready=1).
- ready  out  1  1 = fill complete, ports accept requests.
- a_req  in  1  port A access valid this cycle.
- a_addr  in  ADDR_W  port A byte address (any alignment).
- a_we  in  4  port A byte write strobes; bit i writes a_wdata[8i+7:8i] to byte addr+i.
- a_wdata  in  32  port A write data.
- a_rdata  out  32  port A read data, little-endian: {m[addr+3], m[addr+2], m[addr+1], m[addr]}.
- a_rvalid  out  1  port A read data valid.
- a_err  out  1  port A range error, aligned with a_rvalid.
- b_req, b_addr, b_we, b_wdata, b_rdata, b_rvalid, b_err: identical to the port A signals, for port B.

## Operation
- **States:** FILL and RUN.
  - Reset forces FILL with word counter = 0.
  - FILL: each edge writes FILL_WORD to word[counter] and increments the counter. On the edge that writes the last word (DEPTH_BYTES/4 − 1), go to RUN.
  - RUN with init_req=1 on an edge: go to FILL and set the counter to 0.
- ready = (state == RUN).
- **Requests during FILL:** ignored. No writes, rvalid=0, err=0.
- **Access in RUN** (x_req=1):
  - Out of range, a_addr ≥ DEPTH_BYTES: err=1, rdata=0, all byte writes suppressed.
  - In range: the byte indices addr+i are taken modulo DEPTH_BYTES, so an access starting in the last 3 bytes wraps to byte 0.
- **Writes:** committed on the rising edge for every set strobe bit.
- **Reads:** every request with x_req=1 produces a read, including requests with write strobes.
  - Read data is the array contents before that edge's writes (read-old on both ports).
- **Collision:** if both ports write the same byte on the same edge, port B's byte is stored; port A's write to that byte is dropped. Non-overlapping bytes from both ports are all written.
- **RD_LAT=0:**
  - rdata and err are combinational from the current address and array.
  - rvalid = x_req & ready.
- **RD_LAT=1:**
  - rdata, err and rvalid are registered; rvalid = registered (x_req & ready).
  - rdata and err hold their last values while rvalid=0.
- **Reset values:** ready=0, a/b_rvalid=0, a/b_rdata=0, a/b_err=0, state FILL, counter 0. Array contents are not reset, only refilled by the sequencer.

## Timing
- Fill takes DEPTH_BYTES/4 edges after rst_n deasserts; ready reads 1 after edge N = DEPTH_BYTES/4 (256 edges at the defaults).
- rst_n asserted mid-fill or mid-access: outputs drop to reset values immediately and asynchronously; the fill restarts from word 0.
- init_req in RUN: ready falls after that edge. A request presented in the same cycle is still serviced; its write commits and, with RD_LAT=1, its rvalid appears on the following edge. The sequencer then overwrites the whole array.
- Read latency: 0 cycles (RD_LAT=0) or 1 edge (RD_LAT=1). Both ports accept a new request every cycle; no back-pressure in RUN.
- Write-then-read of the same byte: the new data is visible to a request on the next cycle from either port.

## Test plan
- **Reset and fill:** release rst_n.
  - ready=0 for 255 edges and 1 after the 256th.
  - Port A reads at 0x000, 0x004 and 0x3FC all return 0x275EFBCF.
- **Byte strobes:**
  - A write addr=0x010, we=4'b0101, wdata=0xAABBCCDD, then read 0x010 → 0x27BBFBDD.
  - With RD_LAT=1, rvalid pulses exactly one cycle after each request.
- **Wrap and range:**
  - B write addr=0x3FE, we=4'hF, wdata=0x11223344; read 0x3FE → 0x11223344 and read 0x000 → 0x275E1122.
  - Read at 0x400 → err=1, rdata=0, memory unchanged.
- **Collision:**
  - Same edge: A writes 0x020 with 0x01010101, B writes 0x022 with 0x02020202 (both we=4'hF). Read 0x020 → 0x02020101; read 0x024 → 0x275E0202.
  - A read 0x020 issued on the collision edge returns the pre-write value 0x275EFBCF.
- **init_req and mid-fill reset:**
  - After dirtying word 0x040, pulse init_req: ready drops and returns after 256 edges; 0x040 reads 0x275EFBCF.
  - Assert rst_n at fill edge 100: the next fill again takes 256 edges.
- **RD_LAT=0 build:** repeat the byte-strobe scenario; rdata updates in the same cycle as the request, and rvalid = a_req & ready.
